// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_DBG = 1'b1
   } port_t;

   // Inactive level of every active-low SRAM strobe.
   localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection; last_grant only moves on contention.
module rr_arbiter2
   import sram_arb_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic       grant_valid,
   output logic       grant_id
);

   logic last_q, last_d;

   // Pick the winner; a tie goes to the port that did not win the previous tie.
   always_comb begin
      grant_valid = |req;
      grant_id    = PORT_CPU;
      last_d      = last_q;
      case (req)
         2'b01: grant_id = PORT_CPU;
         2'b10: grant_id = PORT_DBG;
         2'b11: begin
            grant_id = (last_q == PORT_DBG) ? PORT_CPU : PORT_DBG;
            if (update) last_d = grant_id;
         end
         default: grant_id = PORT_CPU;
      endcase
   end

   // Reset to dbg so the CPU wins the first contention.
   always_ff @(posedge Clk) begin
      if (!Reset) last_q <= PORT_DBG;
      else        last_q <= last_d;
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the CPU and debug ports with a
// setup / strobe / hold access sequence.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 20,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned WAIT_CYC = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic              busy,
   output logic              Mem_CE,
   output logic              Mem_UB,
   output logic              Mem_LB,
   output logic              Mem_OE,
   output logic              Mem_WE,
   output logic [ADDR_W-1:0] ADDR,
   inout  wire  [DATA_W-1:0] Data
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              port_q, port_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
   logic              cpu_ack_q, cpu_ack_d, dbg_ack_q, dbg_ack_d;
   logic              busy_q, busy_d;
   logic              ce_q, ce_d, oe_q, oe_d, wen_q, wen_d;
   logic              drv_q, drv_d;
   logic              grant_valid, grant_id, upd;
   logic              active, capture;

   rr_arbiter2 u_arb (
      .Clk         (Clk),
      .Reset       (Reset),
      .req         ({dbg_req, cpu_req}),
      .update      (upd),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // Next-state, request latching, read capture and next strobe levels.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      port_d      = port_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      upd         = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               upd    = 1'b1;
               port_d = grant_id;
               cnt_d  = '0;
               if (grant_id == PORT_DBG) begin
                  we_d    = dbg_we;
                  addr_d  = dbg_addr;
                  wdata_d = dbg_wdata;
               end else begin
                  we_d    = cpu_we;
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
               end
               state_d = SETUP;
            end
         end
         SETUP:   state_d = ACCESS;
         ACCESS: begin
            if (cnt_q == CNT_LAST) state_d = DONE;
            else                   cnt_d   = cnt_q + CNT_W'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Read data is sampled on the edge that closes the last strobe cycle.
      capture = (state_q == ACCESS) && (cnt_q == CNT_LAST) && !we_q;
      if (capture && (port_q == PORT_CPU)) cpu_rdata_d = Data;
      if (capture && (port_q == PORT_DBG)) dbg_rdata_d = Data;

      active    = (state_d != IDLE);
      busy_d    = active;
      ce_d      = active ? ~STROBE_OFF : STROBE_OFF;
      oe_d      = (active && !we_d && (state_d != DONE)) ? ~STROBE_OFF : STROBE_OFF;
      wen_d     = (we_d && (state_d == ACCESS)) ? ~STROBE_OFF : STROBE_OFF;
      drv_d     = active && we_d;
      cpu_ack_d = (state_d == DONE) && (port_d == PORT_CPU);
      dbg_ack_d = (state_d == DONE) && (port_d == PORT_DBG);
   end

   // State and registered outputs; reset abandons any access in flight.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         port_q      <= PORT_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         dbg_ack_q   <= 1'b0;
         busy_q      <= 1'b0;
         ce_q        <= STROBE_OFF;
         oe_q        <= STROBE_OFF;
         wen_q       <= STROBE_OFF;
         drv_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         port_q      <= port_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
         cpu_ack_q   <= cpu_ack_d;
         dbg_ack_q   <= dbg_ack_d;
         busy_q      <= busy_d;
         ce_q        <= ce_d;
         oe_q        <= oe_d;
         wen_q       <= wen_d;
         drv_q       <= drv_d;
      end
   end

   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign busy      = busy_q;
   assign Mem_CE    = ce_q;
   assign Mem_UB    = ce_q;
   assign Mem_LB    = ce_q;
   assign Mem_OE    = oe_q;
   assign Mem_WE    = wen_q;
   assign ADDR      = addr_q;
   assign Data      = drv_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vectors, corner sequences and a
// randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_sram_arbiter;

   localparam int W = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [19:0] cpu_addr, dbg_addr;
   logic [15:0] cpu_wdata, dbg_wdata;
   logic [15:0] cpu_rdata, dbg_rdata;
   logic        cpu_ack, dbg_ack, busy;
   logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
   logic [19:0] ADDR;
   wire  [15:0] Data;

   always #5 Clk = ~Clk;

   sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(W)) dut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .busy(busy), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
      .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR), .Data(Data)
   );

   // SRAM model: 256 words, read drives the bus, write stores on the clock.
   logic [15:0] mem [0:255];
   logic        pre_en;
   logic [7:0]  pre_addr;
   logic [15:0] pre_data;
   assign Data = (!Mem_CE && !Mem_OE && Mem_WE) ? mem[ADDR[7:0]] : 16'hzzzz;
   always @(posedge Clk) begin
      if (pre_en)                   mem[pre_addr]   <= pre_data;
      else if (!Mem_CE && !Mem_WE)  mem[ADDR[7:0]]  <= Data;
   end

   // Two extra instances for the wait-count extremes, each with a fixed-value bus.
   logic        s1_req, s15_req, s1_ack, s15_ack, s1_busy, s15_busy;
   logic [15:0] s1_rd, s15_rd, s1_drd, s15_drd;
   logic        s1_dack, s15_dack;
   logic        s1_ce, s1_ub, s1_lb, s1_oe, s1_we, s15_ce, s15_ub, s15_lb, s15_oe, s15_we;
   logic [19:0] s1_addr, s15_addr;
   wire  [15:0] s1_data, s15_data;
   assign s1_data  = (!s1_ce && !s1_oe)   ? 16'h0A5A : 16'hzzzz;
   assign s15_data = (!s15_ce && !s15_oe) ? 16'hC3C3 : 16'hzzzz;

   sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(1)) dut_w1 (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(s1_req), .cpu_we(1'b0), .cpu_addr(20'h1), .cpu_wdata(16'h0),
      .cpu_rdata(s1_rd), .cpu_ack(s1_ack),
      .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(20'h0), .dbg_wdata(16'h0),
      .dbg_rdata(s1_drd), .dbg_ack(s1_dack),
      .busy(s1_busy), .Mem_CE(s1_ce), .Mem_UB(s1_ub), .Mem_LB(s1_lb),
      .Mem_OE(s1_oe), .Mem_WE(s1_we), .ADDR(s1_addr), .Data(s1_data)
   );

   sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(15)) dut_w15 (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(s15_req), .cpu_we(1'b0), .cpu_addr(20'h2), .cpu_wdata(16'h0),
      .cpu_rdata(s15_rd), .cpu_ack(s15_ack),
      .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(20'h0), .dbg_wdata(16'h0),
      .dbg_rdata(s15_drd), .dbg_ack(s15_dack),
      .busy(s15_busy), .Mem_CE(s15_ce), .Mem_UB(s15_ub), .Mem_LB(s15_lb),
      .Mem_OE(s15_oe), .Mem_WE(s15_we), .ADDR(s15_addr), .Data(s15_data)
   );

   int total = 0;
   int bad   = 0;
   int inv_cnt = 0;

   // Bus-safety invariants sampled every cycle on the main instance.
   always @(negedge Clk) begin
      if (!Mem_OE && !Mem_WE)  inv_cnt++;
      if (!Mem_OE && dut.drv_q) inv_cnt++;
      if (cpu_ack && dbg_ack)  inv_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Model state: memory contents, per-port read registers, tie-break owner.
   logic [15:0] model_mem [0:255];
   logic [15:0] model_rd [2];
   logic        model_last;

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      @(posedge Clk); #1;
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      model_mem[a] = d;
      @(posedge Clk); #1;
      pre_en = 1'b0;
   endtask

   task automatic reset_dut();
      @(posedge Clk); #1; Reset = 1'b0;
      @(posedge Clk); #1; Reset = 1'b1;
      model_rd[0] = '0; model_rd[1] = '0; model_last = 1'b1;
   endtask

   logic [39:0] oe_mask, we_mask, dv_mask;

   // One single-port access; records per-cycle strobe activity from cycle 0.
   task automatic do_access(input logic port, input logic we, input logic [19:0] addr,
                            input logic [15:0] wd, input logic [15:0] dv_val,
                            output logic [15:0] rd, output int lat, output int other);
      lat = -1; other = 0; rd = '0;
      oe_mask = '0; we_mask = '0; dv_mask = '0;
      @(posedge Clk); #1;
      if (port) begin dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd; end
      else      begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
      for (int c = 0; c < 40; c++) begin
         @(negedge Clk);
         oe_mask[c] = !Mem_OE;
         we_mask[c] = !Mem_WE;
         dv_mask[c] = (Data === dv_val) && Mem_OE;
         if (port ? cpu_ack : dbg_ack) other++;
         if (port ? dbg_ack : cpu_ack) begin
            lat = c;
            rd  = port ? dbg_rdata : cpu_rdata;
            break;
         end
         @(posedge Clk); #1;
      end
      @(posedge Clk); #1;
      cpu_req = 1'b0; dbg_req = 1'b0;
   endtask

   // Follow acks of the ports in act, dropping each request after its ack.
   task automatic track(input logic [1:0] act, input int c0,
                        output int cyc0, output int cyc1,
                        output logic [15:0] rd0, output logic [15:0] rd1);
      logic [1:0] seen = 2'b00;
      cyc0 = -1; cyc1 = -1; rd0 = '0; rd1 = '0;
      for (int c = c0; c < c0 + 60; c++) begin
         @(negedge Clk);
         if (cpu_ack) begin cyc0 = c; rd0 = cpu_rdata; seen[0] = 1'b1; end
         if (dbg_ack) begin cyc1 = c; rd1 = dbg_rdata; seen[1] = 1'b1; end
         @(posedge Clk); #1;
         if (seen[0]) cpu_req = 1'b0;
         if (seen[1]) dbg_req = 1'b0;
         if ((seen & act) == act) break;
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
   endtask

   task automatic sweep(input int which, output int lat, output logic [15:0] rd);
      lat = -1; rd = '0;
      @(posedge Clk); #1;
      if (which == 1) s1_req = 1'b1; else s15_req = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge Clk);
         if ((which == 1) ? s1_ack : s15_ack) begin
            lat = c;
            rd  = (which == 1) ? s1_rd : s15_rd;
            break;
         end
         @(posedge Clk); #1;
      end
      @(posedge Clk); #1;
      s1_req = 1'b0; s15_req = 1'b0;
   endtask

   // Random transactions: model serves ports in arbitration order at fixed latencies.
   task automatic random_phase(input int n);
      logic        pwe [2];
      logic [7:0]  pa  [2];
      logic [15:0] pd  [2];
      int          ecyc [2];
      logic [1:0]  act;
      logic        first;
      int          c0, c1;
      logic [15:0] r0, r1;
      for (int it = 0; it < n; it++) begin
         case ($urandom_range(2, 0))
            0:       act = 2'b01;
            1:       act = 2'b10;
            default: act = 2'b11;
         endcase
         for (int p = 0; p < 2; p++) begin
            pwe[p] = 1'($urandom_range(1, 0));
            pa[p]  = 8'h40 + 8'($urandom_range(15, 0));
            pd[p]  = 16'($urandom);
            ecyc[p] = -1;
         end
         if (act == 2'b11) begin
            first = ~model_last;
            model_last = first;
         end else begin
            first = act[1];
         end
         ecyc[first] = 2 + W;
         if (act == 2'b11) ecyc[~first] = (2 + W) + (3 + W);
         for (int k = 0; k < 2; k++) begin
            int p;
            p = (k == 0) ? int'(first) : int'(~first);
            if (act[p]) begin
               if (pwe[p]) model_mem[pa[p]] = pd[p];
               else        model_rd[p] = model_mem[pa[p]];
            end
         end
         @(posedge Clk); #1;
         cpu_req = act[0]; cpu_we = pwe[0]; cpu_addr = {12'h0, pa[0]}; cpu_wdata = pd[0];
         dbg_req = act[1]; dbg_we = pwe[1]; dbg_addr = {12'h0, pa[1]}; dbg_wdata = pd[1];
         track(act, 0, c0, c1, r0, r1);
         chk("rand_cpu_ack_cycle", 32'(c0), 32'(ecyc[0]));
         chk("rand_dbg_ack_cycle", 32'(c1), 32'(ecyc[1]));
         chk("rand_cpu_rdata", 32'(cpu_rdata), 32'(model_rd[0]));
         chk("rand_dbg_rdata", 32'(dbg_rdata), 32'(model_rd[1]));
      end
   endtask

   typedef struct {
      logic        port;
      logic        we;
      logic [19:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t        tbl [7];
   logic [15:0] rd;
   int          lat, other, n, cnt, first_c, c0, c1;
   int          ack_cyc [4];
   logic        ack_port [4];
   logic [15:0] r0, r1;

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      Reset = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      s1_req = 1'b0; s15_req = 1'b0;
      model_rd[0] = '0; model_rd[1] = '0; model_last = 1'b1;
      for (int i = 0; i < 256; i++) model_mem[i] = '0;

      // Reset values while reset is held.
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_strobes", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'h1F);
      chk("rst_addr", 32'(ADDR), 32'h0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
      chk("rst_dbg_rdata", 32'(dbg_rdata), 32'h0);
      chk("rst_ack_busy", 32'({cpu_ack, dbg_ack, busy}), 32'h0);
      chk("rst_data_released", 32'(dut.drv_q), 32'h0);
      @(posedge Clk); #1; Reset = 1'b1;

      for (int i = 0; i < 256; i++) preload(8'(i), 16'h0);
      preload(8'h10, 16'hBEEF);
      for (int i = 0; i < 16; i++) preload(8'h40 + 8'(i), 16'($urandom));

      // Single CPU read.
      do_access(1'b0, 1'b0, 20'h00010, 16'h0, 16'h0, rd, lat, other);
      chk("read_latency", 32'(lat), 32'(2 + W));
      chk("read_rdata", 32'(rd), 32'hBEEF);
      chk("read_oe_cycles", 32'(oe_mask[7:0]), 32'h0E);
      chk("read_we_never", 32'(we_mask[7:0]), 32'h00);
      chk("read_dbg_ack_never", 32'(other), 32'h0);

      // Single debug write.
      do_access(1'b1, 1'b1, 20'h00020, 16'h1234, 16'h1234, rd, lat, other);
      model_mem[8'h20] = 16'h1234;
      chk("write_latency", 32'(lat), 32'(2 + W));
      chk("write_we_cycles", 32'(we_mask[7:0]), 32'h0C);
      chk("write_data_cycles", 32'(dv_mask[7:0]), 32'h1E);
      chk("write_oe_never", 32'(oe_mask[7:0]), 32'h00);
      chk("write_sram_contents", 32'(mem[8'h20]), 32'h1234);
      chk("write_cpu_ack_never", 32'(other), 32'h0);

      // Directed vector table.
      tbl[0] = '{1'b0, 1'b0, 20'h00020, 16'h0000, 16'h1234};
      tbl[1] = '{1'b0, 1'b1, 20'h00030, 16'hA5A5, 16'h0000};
      tbl[2] = '{1'b1, 1'b0, 20'h00030, 16'h0000, 16'hA5A5};
      tbl[3] = '{1'b1, 1'b1, 20'h00031, 16'h0F0F, 16'h0000};
      tbl[4] = '{1'b0, 1'b0, 20'h00031, 16'h0000, 16'h0F0F};
      tbl[5] = '{1'b1, 1'b0, 20'h00010, 16'h0000, 16'hBEEF};
      tbl[6] = '{1'b0, 1'b0, 20'h00030, 16'h0000, 16'hA5A5};
      for (int i = 0; i < 7; i++) begin
         do_access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wdata, rd, lat, other);
         if (tbl[i].we) model_mem[tbl[i].addr[7:0]] = tbl[i].wdata;
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(2 + W));
         chk($sformatf("vec%0d_other_ack", i), 32'(other), 32'h0);
         if (!tbl[i].we) chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
      end

      // Contention right after reset, both held: CPU, DBG, CPU, DBG every 3+W cycles.
      reset_dut();
      @(posedge Clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 20'h00020;
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge Clk);
         if (cpu_ack) begin ack_cyc[n] = c; ack_port[n] = 1'b0; n++; end
         else if (dbg_ack) begin ack_cyc[n] = c; ack_port[n] = 1'b1; n++; end
         if (n < 4) begin @(posedge Clk); #1; end
      end
      @(posedge Clk); #1;
      cpu_req = 1'b0; dbg_req = 1'b0;
      chk("cont_ack_count", 32'(n), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("cont%0d_cycle", i), 32'(ack_cyc[i]), 32'((2 + W) + i * (3 + W)));
         chk($sformatf("cont%0d_port", i), 32'(ack_port[i]), 32'(i % 2));
      end
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("cont_idle_after", 32'(busy), 32'h0);

      // One-cycle request pulse still completes exactly once.
      @(posedge Clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
      @(posedge Clk); #1;
      cpu_req = 1'b0;
      cnt = 0; first_c = -1;
      for (int c = 1; c < 16; c++) begin
         @(negedge Clk);
         if (cpu_ack) begin cnt++; if (first_c < 0) first_c = c; end
         @(posedge Clk); #1;
      end
      chk("drop_ack_count", 32'(cnt), 32'd1);
      chk("drop_ack_cycle", 32'(first_c), 32'(2 + W));
      chk("drop_rdata", 32'(cpu_rdata), 32'hBEEF);

      // Reset during the strobe phase of a write, then a pending pair.
      cnt = 0;
      @(posedge Clk); #1;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 20'h00050; dbg_wdata = 16'h7777;
      @(negedge Clk); cnt += int'(cpu_ack) + int'(dbg_ack);
      @(posedge Clk); #1;
      @(negedge Clk); cnt += int'(cpu_ack) + int'(dbg_ack);
      @(posedge Clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
      Reset = 1'b0;
      @(negedge Clk); cnt += int'(cpu_ack) + int'(dbg_ack);
      chk("midrst_in_access", 32'({busy, Mem_WE}), 32'h2);
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(negedge Clk); cnt += int'(cpu_ack) + int'(dbg_ack);
      chk("midrst_strobes", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'h1F);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_data_released", 32'(dut.drv_q), 32'h0);
      chk("midrst_no_ack", 32'(cnt), 32'h0);
      @(posedge Clk); #1;
      track(2'b11, 4, c0, c1, r0, r1);
      chk("midrst_cpu_first", 32'(c0), 32'd3 + 32'(2 + W));
      chk("midrst_dbg_second", 32'(c1), 32'd3 + 32'(2 + W) + 32'(3 + W));
      chk("midrst_cpu_rdata", 32'(r0), 32'hBEEF);
      model_mem[8'h50] = 16'h7777;

      // Wait-count extremes.
      sweep(1, lat, rd);
      chk("w1_latency", 32'(lat), 32'd3);
      chk("w1_rdata", 32'(rd), 32'h0A5A);
      sweep(15, lat, rd);
      chk("w15_latency", 32'(lat), 32'd17);
      chk("w15_rdata", 32'(rd), 32'hC3C3);

      reset_dut();
      random_phase(40);

      chk("bus_invariants", 32'(inv_cnt), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
